opcode_sequencer: RTL and testbench
===================================

OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

Interface
REQ-001 Parameter DEPTH, 16, number of program slots (index width 4).
REQ-002 Parameter IDLE_OPCODE, 6'd0, opcode driven when no program runs.
REQ-003 Parameter TIMEOUT, 15, max cycles between Control terminal states while running.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 loadEn / loadAddr / loadOpcode  input  1/4/6  program-slot write port.
REQ-007 progLen  input  5  instructions to run (1..16; 0 = start ignored; >16 clamped to 16).
REQ-008 start  input  1  request to run the program from slot 0.
REQ-009 ctrlState  input  4  current state number of the Control FSM (IF=0 … JUMP3=11).
REQ-010 opcode  output  6  registered opcode presented to Control.
REQ-011 busy / done  output  1/1  program running / one-cycle completion pulse.
REQ-012 instrCount  output  8  instructions retired since reset (wraps 255→0).
REQ-013 error / errCause / errIndex  output  1/2/4  sticky fault, cause (0 none, 1 timeout, 2 length), slot index of faulting instruction.

Function
REQ-014 Terminal states: {2,5,6,9,10,11}; the cycle after a terminal state is always IF, so opcode SHALL change only on the edge ending a terminal-state cycle, keeping opcode valid throughout IF (LDI decodes in IF).
REQ-015 FSM states: IDLE, PEND, RUN, ERR.
REQ-016 IDLE: loadEn writes slot loadAddr; start with progLen≠0 and loadEn=0 → PEND; start with loadEn=1 ignored (load has priority).
REQ-017 PEND: busy=1; on first terminal-state cycle, opcode←prog[0], index←1, → RUN.
REQ-018 RUN: on each terminal-state cycle, current instruction retires (instrCount+1); if index<len, opcode←prog[index], index+1; else opcode←IDLE_OPCODE, done=1 for one cycle, → IDLE.
REQ-019 loadEn and start outside IDLE SHALL be ignored; program memory unchanged.
REQ-020 busy=1 in PEND and RUN only.
REQ-021 Timeout: in RUN, if TIMEOUT consecutive cycles pass with no terminal state, error←1, errCause←1, errIndex←slot in flight, opcode←IDLE_OPCODE, → ERR.
REQ-022 ERR: all inputs except reset ignored; error held.
REQ-023 Single-instruction program (progLen=1): issue and retirement SHALL produce done exactly one Control instruction after issue.

Reset
REQ-024 Asynchronous reset SHALL immediately force: state IDLE, opcode=IDLE_OPCODE, busy=0, done=0, instrCount=0, error=0, errCause=0, errIndex=0, index=0, timeout counter=0.
REQ-025 Program memory SHALL NOT be cleared by reset.
REQ-026 Reset mid-run SHALL abandon the program with no done pulse; it is the only exit from ERR.

Configuration
REQ-027 Macro SEQ_LENGTH_CHECK_EN defined: cycles from IF through terminal state (inclusive) SHALL be counted per instruction and compared against LDI=2, BEQ=3, JUMP=3, ADD/ADDI=4, STR=4, LD=5 (codebase opcode definitions); other opcodes unchecked; mismatch → error=1, errCause=2, errIndex=faulting slot, opcode←IDLE_OPCODE, → ERR.
REQ-028 Macro undefined: no length counter, errCause never 2, timeout the only fault.

Verification
REQ-029 Load [ADD,ADDI,BEQ,LD,STR,JUMP,LDI], progLen=7, start -> opcodes change only at terminal edges, Control paths 4/4/3/5/4/3/2 cycles, done one cycle after LDI terminal, instrCount=7.
REQ-030 progLen=0 with start, and start with loadEn same cycle -> busy stays 0, no opcode change.
REQ-031 Run progLen=3, hold ctrlState=1 for 15 cycles -> error=1, errCause=1, errIndex=slot in flight, opcode=IDLE_OPCODE, state ERR until reset.
REQ-032 SEQ_LENGTH_CHECK_EN defined, slot0=LD, force ctrlState IF,RF,7,10 (missing LOAD4) -> errCause=2, errIndex=0; undefined -> runs to done.
REQ-033 Assert reset mid-RUN between clock edges -> outputs reach reset values before next edge, program memory retained, restart runs same program.
REQ-034 Run 256 single-instruction programs -> instrCount wraps to 0, each run one done pulse.

Source files
------------

// File: rtl/opcode_sequencer.sv
// Opcode sequencer: feeds a stored program of opcodes to the Control FSM, one per instruction.
// Optional per-instruction path-length checking is enabled by defining SEQ_LENGTH_CHECK_EN.
module opcode_sequencer #(
  parameter int         DEPTH       = 16,
  parameter logic [5:0] IDLE_OPCODE = 6'd0,
  parameter int         TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       loadEn,
  input  logic [3:0] loadAddr,
  input  logic [5:0] loadOpcode,
  input  logic [4:0] progLen,
  input  logic       start,
  input  logic [3:0] ctrlState,
  output logic [5:0] opcode,
  output logic       busy,
  output logic       done,
  output logic [7:0] instrCount,
  output logic       error,
  output logic [1:0] errCause,
  output logic [3:0] errIndex
);

  typedef enum logic [1:0] {IDLE, PEND, RUN, ERR} seqState_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [4:0] MAXLEN  = 5'(DEPTH);

  seqState_t  state, stateNext;
  logic [5:0] prog [DEPTH];
  logic [5:0] opcodeNext;
  logic [4:0] idx, idxNext, len, lenNext;
  logic [7:0] countNext, toCount, toCountNext;
  logic       doneNext, errorNext, fault, isTerm, lenFault;
  logic [1:0] causeNext, faultCause;
  logic [3:0] errIdxNext;

  // A terminal state is the last cycle of a Control instruction; the next cycle is always IF.
  assign isTerm = ctrlState inside {4'd2, 4'd5, 4'd6, 4'd9, 4'd10, 4'd11};
  assign busy   = (state == PEND) || (state == RUN);

`ifdef SEQ_LENGTH_CHECK_EN
  localparam logic [5:0] OP_LDI  = 6'd1;
  localparam logic [5:0] OP_ADD  = 6'd2;
  localparam logic [5:0] OP_ADDI = 6'd3;
  localparam logic [5:0] OP_LD   = 6'd4;
  localparam logic [5:0] OP_STR  = 6'd5;
  localparam logic [5:0] OP_BEQ  = 6'd6;
  localparam logic [5:0] OP_JUMP = 6'd7;

  logic [7:0] lenCount, lenCountNext;

  // Expected IF-to-terminal cycle count; zero marks an opcode with no fixed path.
  function automatic logic [7:0] expLen(input logic [5:0] op);
    case (op)
      OP_LDI:          expLen = 8'd2;
      OP_BEQ, OP_JUMP: expLen = 8'd3;
      OP_ADD, OP_ADDI: expLen = 8'd4;
      OP_STR:          expLen = 8'd4;
      OP_LD:           expLen = 8'd5;
      default:         expLen = 8'd0;
    endcase
  endfunction

  assign lenFault = (expLen(opcode) != 8'd0) && ((lenCount + 8'd1) != expLen(opcode));
`else
  assign lenFault = 1'b0;
`endif

  // Program memory is deliberately outside the reset domain so programs survive reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && loadEn)
      prog[loadAddr] <= loadOpcode;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      opcode     <= IDLE_OPCODE;
      idx        <= '0;
      len        <= '0;
      done       <= 1'b0;
      instrCount <= '0;
      error      <= 1'b0;
      errCause   <= '0;
      errIndex   <= '0;
      toCount    <= '0;
`ifdef SEQ_LENGTH_CHECK_EN
      lenCount   <= '0;
`endif
    end else begin
      state      <= stateNext;
      opcode     <= opcodeNext;
      idx        <= idxNext;
      len        <= lenNext;
      done       <= doneNext;
      instrCount <= countNext;
      error      <= errorNext;
      errCause   <= causeNext;
      errIndex   <= errIdxNext;
      toCount    <= toCountNext;
`ifdef SEQ_LENGTH_CHECK_EN
      lenCount   <= lenCountNext;
`endif
    end
  end

  // Opcode only moves on the edge closing a terminal cycle, so it is stable for all of IF.
  always_comb begin
    stateNext   = state;
    opcodeNext  = opcode;
    idxNext     = idx;
    lenNext     = len;
    doneNext    = 1'b0;
    countNext   = instrCount;
    errorNext   = error;
    causeNext   = errCause;
    errIdxNext  = errIndex;
    toCountNext = toCount;
    fault       = 1'b0;
    faultCause  = 2'd0;
`ifdef SEQ_LENGTH_CHECK_EN
    lenCountNext = lenCount;
`endif
    case (state)
      IDLE: begin
        if (start && !loadEn && progLen != 5'd0) begin
          stateNext = PEND;
          lenNext   = (progLen > MAXLEN) ? MAXLEN : progLen;
        end
      end
      PEND: begin
        if (isTerm) begin
          opcodeNext  = prog[0];
          idxNext     = 5'd1;
          toCountNext = '0;
          stateNext   = RUN;
`ifdef SEQ_LENGTH_CHECK_EN
          lenCountNext = '0;
`endif
        end
      end
      RUN: begin
        if (isTerm && lenFault) begin
          fault      = 1'b1;
          faultCause = 2'd2;
        end else if (isTerm) begin
          countNext   = instrCount + 8'd1;
          toCountNext = '0;
`ifdef SEQ_LENGTH_CHECK_EN
          lenCountNext = '0;
`endif
          if (idx < len) begin
            opcodeNext = prog[idx[3:0]];
            idxNext    = idx + 5'd1;
          end else begin
            opcodeNext = IDLE_OPCODE;
            idxNext    = '0;
            doneNext   = 1'b1;
            stateNext  = IDLE;
          end
        end else if (toCount == TO_LAST) begin
          fault      = 1'b1;
          faultCause = 2'd1;
        end else begin
          toCountNext = toCount + 8'd1;
`ifdef SEQ_LENGTH_CHECK_EN
          lenCountNext = lenCount + 8'd1;
`endif
        end
        if (fault) begin
          errorNext  = 1'b1;
          causeNext  = faultCause;
          errIdxNext = 4'(idx - 5'd1);
          opcodeNext = IDLE_OPCODE;
          stateNext  = ERR;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed self-checking bench for opcode_sequencer: full program, ignored starts, timeout,
// length check, mid-run reset and instrCount wrap over 256 single-instruction runs.
module tb_opcode_sequencer;

  localparam logic [5:0] IDLE = 6'd0;
  localparam logic [5:0] LDI  = 6'd1;
  localparam logic [5:0] ADD  = 6'd2;
  localparam logic [5:0] ADDI = 6'd3;
  localparam logic [5:0] LD   = 6'd4;
  localparam logic [5:0] STR  = 6'd5;
  localparam logic [5:0] BEQ  = 6'd6;
  localparam logic [5:0] JUMP = 6'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic       loadEn;
  logic [3:0] loadAddr;
  logic [5:0] loadOpcode;
  logic [4:0] progLen;
  logic       start;
  logic [3:0] ctrlState;
  logic [5:0] opcode;
  logic       busy, done, error;
  logic [7:0] instrCount;
  logic [1:0] errCause;
  logic [3:0] errIndex;

  int checks = 0;
  int errors = 0;
  logic [5:0] progOps [7];
  int         pathLen [7];

  opcode_sequencer dut (
    .clk(clk), .reset(reset), .loadEn(loadEn), .loadAddr(loadAddr), .loadOpcode(loadOpcode),
    .progLen(progLen), .start(start), .ctrlState(ctrlState), .opcode(opcode), .busy(busy),
    .done(done), .instrCount(instrCount), .error(error), .errCause(errCause), .errIndex(errIndex)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive ctrlState for one cycle; returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic [3:0] cs);
    ctrlState = cs;
    @(posedge clk);
    #1;
  endtask

  task automatic loadSlot(input logic [3:0] addr, input logic [5:0] op);
    loadEn = 1'b1; loadAddr = addr; loadOpcode = op;
    applyStimulus(4'd1);
    loadEn = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    applyStimulus(4'd1);
    reset = 1'b0;
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    checkOutput("rst_count", {24'd0, instrCount}, 32'd0);
    checkOutput("rst_opcode", {26'd0, opcode}, {26'd0, IDLE});
  endtask

  task automatic runProgram(input logic [7:0] base);
    start = 1'b1; progLen = 5'd7;
    applyStimulus(4'd1);
    start = 1'b0;
    checkOutput("pend_busy", {31'd0, busy}, 32'd1);
    checkOutput("pend_opcode", {26'd0, opcode}, {26'd0, IDLE});
    applyStimulus(4'd9);
    checkOutput("issue0", {26'd0, opcode}, {26'd0, progOps[0]});
    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < pathLen[i] - 1; c++) begin
        applyStimulus(c == 0 ? 4'd0 : 4'd1);
        checkOutput($sformatf("hold_opcode_%0d_%0d", i, c), {26'd0, opcode}, {26'd0, progOps[i]});
      end
      applyStimulus(4'd10);
      checkOutput($sformatf("retire_count_%0d", i), {24'd0, instrCount}, {24'd0, base + 8'(i + 1)});
      checkOutput($sformatf("next_opcode_%0d", i), {26'd0, opcode}, {26'd0, (i < 6) ? progOps[i + 1] : IDLE});
      checkOutput($sformatf("done_%0d", i), {31'd0, done}, {31'd0, 1'(i == 6)});
    end
    applyStimulus(4'd0);
    checkOutput("done_clear", {31'd0, done}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    progOps = '{ADD, ADDI, BEQ, LD, STR, JUMP, LDI};
    pathLen = '{4, 4, 3, 5, 4, 3, 2};
    reset = 1'b1; loadEn = 1'b0; loadAddr = '0; loadOpcode = '0;
    progLen = '0; start = 1'b0; ctrlState = 4'd1;
    #3;
    checkOutput("reset_opcode", {26'd0, opcode}, {26'd0, IDLE});
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_count", {24'd0, instrCount}, 32'd0);
    checkOutput("reset_err", {27'd0, error, errCause, errIndex}, 32'd0);
    applyStimulus(4'd1);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) loadSlot(4'(i), progOps[i]);

    // Ignored starts: zero length, and start colliding with a load.
    start = 1'b1; progLen = 5'd0;
    applyStimulus(4'd2);
    checkOutput("len0_busy", {31'd0, busy}, 32'd0);
    progLen = 5'd7; loadEn = 1'b1; loadAddr = 4'd15; loadOpcode = STR;
    applyStimulus(4'd2);
    loadEn = 1'b0; start = 1'b0;
    checkOutput("loadstart_busy", {31'd0, busy}, 32'd0);
    applyStimulus(4'd2);
    checkOutput("ignored_opcode", {26'd0, opcode}, {26'd0, IDLE});

    runProgram(8'd0);
    checkOutput("prog_count", {24'd0, instrCount}, 32'd7);

    // Timeout with slot 1 in flight.
    start = 1'b1; progLen = 5'd3;
    applyStimulus(4'd1);
    start = 1'b0;
    applyStimulus(4'd5);
    applyStimulus(4'd0); applyStimulus(4'd1); applyStimulus(4'd1); applyStimulus(4'd10);
    checkOutput("to_slot1", {26'd0, opcode}, {26'd0, ADDI});
    repeat (14) applyStimulus(4'd1);
    checkOutput("to_not_yet", {31'd0, error}, 32'd0);
    checkOutput("to_busy", {31'd0, busy}, 32'd1);
    applyStimulus(4'd1);
    checkOutput("to_error", {31'd0, error}, 32'd1);
    checkOutput("to_cause", {30'd0, errCause}, 32'd1);
    checkOutput("to_index", {28'd0, errIndex}, 32'd1);
    checkOutput("to_opcode", {26'd0, opcode}, {26'd0, IDLE});
    checkOutput("to_notbusy", {31'd0, busy}, 32'd0);
    start = 1'b1; loadEn = 1'b1; loadAddr = 4'd0; loadOpcode = LDI;
    applyStimulus(4'd2);
    start = 1'b0; loadEn = 1'b0;
    applyStimulus(4'd2);
    checkOutput("err_held", {31'd0, error}, 32'd1);
    checkOutput("err_busy", {31'd0, busy}, 32'd0);
    checkOutput("err_count", {24'd0, instrCount}, 32'd8);
    pulseReset();

    // Mid-run asynchronous reset between edges, then the same program again.
    start = 1'b1; progLen = 5'd7;
    applyStimulus(4'd1);
    start = 1'b0;
    applyStimulus(4'd6);
    checkOutput("mem_kept", {26'd0, opcode}, {26'd0, ADD});
    applyStimulus(4'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_opcode", {26'd0, opcode}, {26'd0, IDLE});
    checkOutput("async_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_done", {31'd0, done}, 32'd0);
    #1 reset = 1'b0;
    runProgram(8'd0);

    // Short LD path (IF,RF,7,10 is one cycle short of LD's five).
    loadSlot(4'd0, LD);
    start = 1'b1; progLen = 5'd1;
    applyStimulus(4'd1);
    start = 1'b0;
    applyStimulus(4'd2);
    applyStimulus(4'd0); applyStimulus(4'd1); applyStimulus(4'd7); applyStimulus(4'd10);
`ifdef SEQ_LENGTH_CHECK_EN
    checkOutput("len_error", {31'd0, error}, 32'd1);
    checkOutput("len_cause", {30'd0, errCause}, 32'd2);
    checkOutput("len_index", {28'd0, errIndex}, 32'd0);
    checkOutput("len_opcode", {26'd0, opcode}, {26'd0, IDLE});
`else
    checkOutput("len_done", {31'd0, done}, 32'd1);
    checkOutput("len_noerr", {31'd0, error}, 32'd0);
    checkOutput("len_count", {24'd0, instrCount}, 32'd8);
`endif
    pulseReset();

    // 256 single-instruction runs wrap instrCount back to zero.
    loadSlot(4'd0, LDI);
    for (int k = 0; k < 256; k++) begin
      start = 1'b1; progLen = 5'd1;
      applyStimulus(4'd1);
      start = 1'b0;
      checkOutput($sformatf("wrap_nodone_%0d", k), {31'd0, done}, 32'd0);
      applyStimulus(4'd2);
      checkOutput($sformatf("wrap_issue_%0d", k), {26'd0, opcode}, {26'd0, LDI});
      applyStimulus(4'd0);
      applyStimulus(4'd11);
      checkOutput($sformatf("wrap_done_%0d", k), {31'd0, done}, 32'd1);
      checkOutput($sformatf("wrap_count_%0d", k), {24'd0, instrCount}, {24'd0, 8'(k + 1)});
    end
    applyStimulus(4'd1);
    checkOutput("wrap_final", {24'd0, instrCount}, 32'd0);
    checkOutput("wrap_done_clear", {31'd0, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
